// File: rtl/jzjpcc_hazard_control.sv
// ============================================================================
// Module   : jzjpcc_hazard_control
// Purpose  : Pipeline sequencing for the five-stage core. Tracks destination
//            registers in execute/memory, raises stall/flush/bubble controls
//            and registers operand-forwarding selects for execute.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_hazard_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs1Addr_decode,
  input  logic [4:0] rs2Addr_decode,
  input  logic       rs1Used_decode,
  input  logic       rs2Used_decode,
  input  logic [4:0] rdAddr_decode,
  input  logic       rdWriteEnable_decode,
  input  logic       isLoad_decode,
  input  logic       pcCTWriteEnable,
  input  logic       stallRequest,
  output logic       decodeValid,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_decode,
  output logic       bubble_execute,
  output logic       freeze_backend,
  output logic [1:0] fwdRs1_execute,
  output logic [1:0] fwdRs2_execute
);

  localparam logic [1:0] FWD_REGFILE   = 2'd0;
  localparam logic [1:0] FWD_MEMORY    = 2'd1;
  localparam logic [1:0] FWD_WRITEBACK = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } sb_entry_t;

  sb_entry_t  ex_q, ex_d;
  sb_entry_t  mem_q, mem_d;
  sb_entry_t  decode_entry;
  logic       decode_valid_q, decode_valid_d;
  logic [1:0] fwd_rs1_q, fwd_rs1_d;
  logic [1:0] fwd_rs2_q, fwd_rs2_d;

  logic       load_use;
  logic       ct_taken;
  logic       issue;

  function automatic logic match(input sb_entry_t s, input logic [4:0] r);
    return s.valid & s.we & (s.rd == r) & (r != 5'd0);
  endfunction

  // The most recent producer (execute) wins over the older one (memory).
  function automatic logic [1:0] fwd_select(input logic used, input logic [4:0] r,
                                            input sb_entry_t ex, input sb_entry_t mem);
    if (used && match(ex, r)) begin
      return FWD_MEMORY;
    end else if (used && match(mem, r)) begin
      return FWD_WRITEBACK;
    end
    return FWD_REGFILE;
  endfunction

  always_comb begin
    decode_entry.valid = 1'b1;
    decode_entry.rd    = rdAddr_decode;
    decode_entry.we    = rdWriteEnable_decode;
    decode_entry.load  = isLoad_decode;
  end

  assign load_use = decode_valid_q & ex_q.load &
                    ((rs1Used_decode & match(ex_q, rs1Addr_decode)) |
                     (rs2Used_decode & match(ex_q, rs2Addr_decode)));
  assign ct_taken = decode_valid_q & pcCTWriteEnable & ~load_use & ~stallRequest;
  assign issue    = decode_valid_q & ~load_use & ~stallRequest;

  // Control outputs are held low while reset is asserted so nothing
  // downstream reacts to the state being cleared.
  assign decodeValid    = decode_valid_q;
  assign stall_fetch    = (load_use | stallRequest) & ~reset;
  assign stall_decode   = (load_use | stallRequest) & ~reset;
  assign freeze_backend = stallRequest & ~reset;
  assign bubble_execute = (load_use | ~decode_valid_q) & ~stallRequest & ~reset;
  assign flush_decode   = ct_taken & ~reset;
  assign fwdRs1_execute = fwd_rs1_q;
  assign fwdRs2_execute = fwd_rs2_q;

  always_comb begin
    ex_d           = ex_q;
    mem_d          = mem_q;
    decode_valid_d = decode_valid_q;
    fwd_rs1_d      = fwd_rs1_q;
    fwd_rs2_d      = fwd_rs2_q;
    if (!stallRequest) begin
      mem_d = ex_q;
      if (issue) begin
        ex_d      = decode_entry;
        fwd_rs1_d = fwd_select(rs1Used_decode, rs1Addr_decode, ex_q, mem_q);
        fwd_rs2_d = fwd_select(rs2Used_decode, rs2Addr_decode, ex_q, mem_q);
      end else begin
        ex_d      = '0;
        fwd_rs1_d = FWD_REGFILE;
        fwd_rs2_d = FWD_REGFILE;
      end
      if (ct_taken) begin
        decode_valid_d = 1'b0;
      end else if (!load_use) begin
        decode_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q           <= '0;
      mem_q          <= '0;
      decode_valid_q <= 1'b0;
      fwd_rs1_q      <= FWD_REGFILE;
      fwd_rs2_q      <= FWD_REGFILE;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      decode_valid_q <= decode_valid_d;
      fwd_rs1_q      <= fwd_rs1_d;
      fwd_rs2_q      <= fwd_rs2_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jzjpcc_hazard_control.sv
// ============================================================================
// Module   : tb_jzjpcc_hazard_control
// Purpose  : Directed self-checking bench for jzjpcc_hazard_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jzjpcc_hazard_control;

  logic       clock;
  logic       reset;
  logic [4:0] rs1Addr_decode, rs2Addr_decode, rdAddr_decode;
  logic       rs1Used_decode, rs2Used_decode;
  logic       rdWriteEnable_decode, isLoad_decode;
  logic       pcCTWriteEnable, stallRequest;
  logic       decodeValid, stall_fetch, stall_decode, flush_decode;
  logic       bubble_execute, freeze_backend;
  logic [1:0] fwdRs1_execute, fwdRs2_execute;

  typedef struct {
    string      tag;
    logic       dv, st, fl, bu, fr;
    logic [1:0] f1, f2;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared;
  int   n_mismatched;

  jzjpcc_hazard_control dut (
    .clock                (clock),
    .reset                (reset),
    .rs1Addr_decode       (rs1Addr_decode),
    .rs2Addr_decode       (rs2Addr_decode),
    .rs1Used_decode       (rs1Used_decode),
    .rs2Used_decode       (rs2Used_decode),
    .rdAddr_decode        (rdAddr_decode),
    .rdWriteEnable_decode (rdWriteEnable_decode),
    .isLoad_decode        (isLoad_decode),
    .pcCTWriteEnable      (pcCTWriteEnable),
    .stallRequest         (stallRequest),
    .decodeValid          (decodeValid),
    .stall_fetch          (stall_fetch),
    .stall_decode         (stall_decode),
    .flush_decode         (flush_decode),
    .bubble_execute       (bubble_execute),
    .freeze_backend       (freeze_backend),
    .fwdRs1_execute       (fwdRs1_execute),
    .fwdRs2_execute       (fwdRs2_execute)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input string field, input logic [1:0] obs, input logic [1:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  // Drive one decode cycle, queue its expectation, then check just before the edge.
  task automatic step(input string tag,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic u1, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic ct, input logic sr, input logic rs,
                      input logic dv, input logic st, input logic fl,
                      input logic bu, input logic fr,
                      input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    @(negedge clock);
    rs1Addr_decode = a1;  rs2Addr_decode = a2;
    rs1Used_decode = u1;  rs2Used_decode = u2;
    rdAddr_decode = rd;   rdWriteEnable_decode = we;
    isLoad_decode = ld;   pcCTWriteEnable = ct;
    stallRequest = sr;    reset = rs;
    e.tag = tag; e.dv = dv; e.st = st; e.fl = fl; e.bu = bu; e.fr = fr; e.f1 = f1; e.f2 = f2;
    exp_q.push_back(e);
    #4;
    e = exp_q.pop_front();
    chk(e.tag, "decodeValid",    {1'b0, decodeValid},    {1'b0, e.dv});
    chk(e.tag, "stall_fetch",    {1'b0, stall_fetch},    {1'b0, e.st});
    chk(e.tag, "stall_decode",   {1'b0, stall_decode},   {1'b0, e.st});
    chk(e.tag, "flush_decode",   {1'b0, flush_decode},   {1'b0, e.fl});
    chk(e.tag, "bubble_execute", {1'b0, bubble_execute}, {1'b0, e.bu});
    chk(e.tag, "freeze_backend", {1'b0, freeze_backend}, {1'b0, e.fr});
    chk(e.tag, "fwdRs1",         fwdRs1_execute,         e.f1);
    chk(e.tag, "fwdRs2",         fwdRs2_execute,         e.f2);
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    reset = 1'b1;
    rs1Addr_decode = '0; rs2Addr_decode = '0; rdAddr_decode = '0;
    rs1Used_decode = 0; rs2Used_decode = 0; rdWriteEnable_decode = 0;
    isLoad_decode = 0; pcCTWriteEnable = 0; stallRequest = 0;
    @(posedge clock);

    //    tag   rs1 rs2 u1 u2 rd we ld ct sr rs | dv st fl bu fr f1 f2
    step("R0",   1,  2, 1, 1, 10, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    // Independent stream after reset
    step("A1",   1,  2, 1, 1, 10, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    step("A2",   3,  4, 1, 1, 11, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("A3",   1,  2, 1, 1, 12, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    // ALU forwarding: back-to-back, one apart, unused rs2
    step("B1",   1,  2, 1, 1,  5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("B2",   5,  6, 1, 1, 13, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("B3",   1,  2, 1, 1, 14, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0);
    step("B4",   1,  2, 1, 1,  5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("B5",   3,  4, 1, 1, 15, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("B6",   5,  8, 1, 1, 16, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("B7",   1,  2, 1, 1,  5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2, 0);
    step("B8",   9,  5, 1, 0, 18, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("B9",   1,  2, 1, 1, 19, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    // Load-use stall, then x0 load never stalls
    step("C1",   1,  0, 1, 0,  7, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("C2",   7,  2, 1, 1, 20, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0);
    step("C3",   7,  2, 1, 1, 20, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("C4",   1,  2, 1, 1, 21, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2, 0);
    step("C5",   1,  2, 1, 1,  0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("C6",   0,  0, 1, 1, 22, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("C7",   1,  2, 1, 1, 23, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    // Control transfer flush; request while decode invalid is ignored
    step("D1",   2,  3, 1, 1,  1, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    step("D2",   1,  3, 1, 1, 24, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    step("D3",   1,  2, 1, 1, 25, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("D4",   3,  4, 1, 1, 26, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2, 0);
    // External freeze over a pending load-use; state and selects hold
    step("E1",  26,  0, 1, 0,  7, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("E2",   7,  2, 1, 1, 27, 1, 0, 1, 1, 0,  1, 1, 0, 0, 1, 1, 0);
    step("E3",   7,  2, 1, 1, 27, 1, 0, 1, 1, 0,  1, 1, 0, 0, 1, 1, 0);
    step("E4",   7,  2, 1, 1, 27, 1, 0, 1, 1, 0,  1, 1, 0, 0, 1, 1, 0);
    step("E5",   7,  2, 1, 1, 27, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1, 0);
    step("E6",   7,  2, 1, 1, 27, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("E7",   1,  2, 1, 1, 28, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2, 0);
    // Reset during a load-use stall with a control transfer pending
    step("F1",  28,  4, 1, 1,  7, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("F2",   7,  2, 1, 1, 29, 1, 0, 1, 0, 1,  1, 0, 0, 0, 0, 1, 0);
    step("F3",   7,  2, 1, 1, 29, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    step("F4",   7,  2, 1, 1, 29, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    step("F5",   1,  2, 1, 1, 30, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jzjpcc_hazard_control.md
Name: jzjpcc_hazard_control

Overview:
Pipeline sequencing controller for the five-stage core (fetch, decode, execute, memory, writeback).
- Keeps an internal scoreboard of destination registers in flight in the execute and memory stages.
- Generates fetch/decode stall, decode flush and execute bubble controls.
- Produces registered operand-forwarding selects for the instruction entering execute.
- Sits beside the decode stage and drives stall_fetch/flush_decode into fetch.

Parameters:
None (register addresses fixed at 5 bits, x0 hardwired zero).

Ports:
clock  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
rs1Addr_decode  input  5  rs1 address of instruction in decode
rs2Addr_decode  input  5  rs2 address of instruction in decode
rs1Used_decode  input  1  decode instruction reads rs1
rs2Used_decode  input  1  decode instruction reads rs2
rdAddr_decode  input  5  rd of decode instruction
rdWriteEnable_decode  input  1  decode instruction writes rd
isLoad_decode  input  1  decode instruction is a load
pcCTWriteEnable  input  1  decode requests control transfer (jump/taken branch)
stallRequest  input  1  external whole-pipeline freeze (e.g. multi-cycle MMIO access)
decodeValid  output  1  instruction currently in decode is real (not a bubble)
stall_fetch  output  1  hold PC and fetch latch
stall_decode  output  1  hold decode latch
flush_decode  output  1  next decode contents become a bubble
bubble_execute  output  1  insert NOP into execute on next edge
freeze_backend  output  1  hold execute/memory/writeback registers
fwdRs1_execute  output  2  rs1 source for execute instruction: 0 regfile, 1 memory-stage result, 2 writeback-stage result
fwdRs2_execute  output  2  same for rs2

Behaviour:
State:
- decodeValid_q.
- Scoreboard entries EX and MEM, each holding {valid, rd[4:0], we, load}.
- fwdRs1_execute and fwdRs2_execute registers.

Reset:
- All scoreboard valid bits 0.
- decodeValid_q 0.
- fwd selects 0.
- All stall/flush/bubble outputs 0.

Combinational terms:
- match(s, r) = s.valid & s.we & s.rd==r & r!=0.
- loadUse = decodeValid_q & EX.load & ((rs1Used_decode & match(EX, rs1Addr_decode)) | (rs2Used_decode & match(EX, rs2Addr_decode))).
- ctTaken = decodeValid_q & pcCTWriteEnable & !loadUse & !stallRequest.

Outputs:
- stall_fetch = stall_decode = loadUse | stallRequest.
- freeze_backend = stallRequest.
- bubble_execute = (loadUse | !decodeValid_q) & !stallRequest.
- flush_decode = ctTaken. A control transfer requested during loadUse or stallRequest is ignored that cycle; decode re-presents it once the stall clears.
- decodeValid = decodeValid_q.

Sequential update on each rising edge (no reset asserted):
- stallRequest = 1: all state holds, including the forwarding selects.
- Otherwise:
  - MEM <= EX.
  - EX <= loadUse or !decodeValid_q ? {0,0,0,0} : decode entry.
  - decodeValid_q <= ctTaken ? 0 : (loadUse ? decodeValid_q : 1).
- On issue (decodeValid_q & !loadUse & !stallRequest), for rsN:
  - fwdRsN_execute <= rsNUsed & match(EX, rsN) ? 1 : (rsNUsed & match(MEM, rsN) ? 2 : 0).
  - EX has priority over MEM (most recent producer wins).
- On a bubble, fwd selects <= 0.

Other rules:
- A load in EX never yields select 1; it always stalls exactly one cycle and then forwards via select 2.
- Writeback-to-decode needs no forwarding: the regfile is written on the negative edge.
- x0 is never forwarded and never stalls.
- After reset, the first decode cycle is a bubble (decodeValid_q=0); the fetch latch fills on that edge.
- Reset mid-stall or mid-flush clears everything; no pending stall survives reset.

Test Plan:
1. Reset, then a stream of independent instructions → decodeValid 0 for cycle 1, then 1; all stall/flush 0; fwd selects 0.
2. ADD x5 issued, then next instruction reads x5 as rs1 → on issue edge fwdRs1_execute=1. With one independent instruction between → fwdRs1_execute=2. Reading x5 as rs2 with rs2Used=0 → 0.
3. LW x7 issued, next instruction reads x7 → stall_fetch=stall_decode=bubble_execute=1 for exactly 1 cycle, then issue with fwdRs1_execute=2. Same case with rd=x0 → no stall.
4. Decode asserts pcCTWriteEnable → flush_decode=1 that cycle; next cycle decodeValid=0 and bubble_execute=1. pcCTWriteEnable while decodeValid=0 → ignored.
5. stallRequest held 3 cycles while a load-use is pending → stall outputs 1 and freeze_backend=1, bubble_execute=0, scoreboard frozen. After release, the 1-cycle load-use stall still occurs.
6. Assert reset for 1 cycle during a load-use stall and with a pending flush → next cycle all outputs at reset values, scoreboard empty.
